int_issue_queue: RTL

- Receiving end of the dispatch-to-issue interface: accepts up to ENQ_WIDTH micro-ops per cycle from the integer dispatch queue, each carrying payload and operand status (rs1/rs2 preg, ready bits, robIdx).
- Holds entries until both operands are ready (via wakeup bus); selects the oldest ready entry by robIdx and presents it on a registered single issue port to the ALU/branch unit.
- Flushes younger entries on backend redirect.

---
 rtl/int_issue_queue_pkg.sv | 21 ++
 rtl/int_issue_queue_if.sv | 39 +++
 rtl/int_issue_queue_age_select.sv | 32 +++
 rtl/int_issue_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared types and the robIdx age compare used by select and flush logic.
package int_issue_queue_pkg;

    localparam int DEPTH      = 8;
    localparam int ENQ_WIDTH  = 2;
    localparam int DATA_WIDTH = 64;
    localparam int PREG_WIDTH = 7;
    localparam int ROB_WIDTH  = 5;
    localparam int WB_WIDTH   = 4;

    typedef struct packed {
        logic                 dir;
        logic [ROB_WIDTH-1:0] idx;
    } rob_idx_t;

    // a is older than b; the dir bit flips each time the ROB pointer wraps
    function automatic logic is_older(input rob_idx_t a, input rob_idx_t b);
        return (a.dir == b.dir) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch, wakeup, redirect and issue signals between the integer backend and the issue queue.
interface int_issue_queue_if;
    import int_issue_queue_pkg::*;

    logic [ENQ_WIDTH-1:0]                 dis_en;
    logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0] dis_data;
    logic [ENQ_WIDTH-1:0][PREG_WIDTH-1:0] dis_rs1;
    logic [ENQ_WIDTH-1:0][PREG_WIDTH-1:0] dis_rs2;
    logic [ENQ_WIDTH-1:0]                 dis_rs1v;
    logic [ENQ_WIDTH-1:0]                 dis_rs2v;
    rob_idx_t [ENQ_WIDTH-1:0]             dis_robIdx;
    logic                                 full;

    logic [WB_WIDTH-1:0]                  wakeup_en;
    logic [WB_WIDTH-1:0][PREG_WIDTH-1:0]  wakeup_preg;

    logic                                 redirect;
    rob_idx_t                             redirect_idx;

    logic                                 issue_valid;
    logic [DATA_WIDTH-1:0]                issue_data;
    logic [PREG_WIDTH-1:0]                issue_rs1;
    logic [PREG_WIDTH-1:0]                issue_rs2;
    rob_idx_t                             issue_robIdx;
    logic                                 issue_ready;

    modport master (
        output dis_en, dis_data, dis_rs1, dis_rs2, dis_rs1v, dis_rs2v, dis_robIdx,
        output wakeup_en, wakeup_preg, redirect, redirect_idx, issue_ready,
        input  full, issue_valid, issue_data, issue_rs1, issue_rs2, issue_robIdx
    );

    modport slave (
        input  dis_en, dis_data, dis_rs1, dis_rs2, dis_rs1v, dis_rs2v, dis_robIdx,
        input  wakeup_en, wakeup_preg, redirect, redirect_idx, issue_ready,
        output full, issue_valid, issue_data, issue_rs1, issue_rs2, issue_robIdx
    );

endinterface

// File: rtl/int_issue_queue_age_select.sv
// Combinational oldest-ready picker: pairwise age matrix, one-hot grant.
module age_select
    import int_issue_queue_pkg::*;
#(
    parameter int N = DEPTH
) (
    input  logic [N-1:0]     req,
    input  rob_idx_t [N-1:0] age,
    output logic [N-1:0]     grant,
    output logic             gnt_vld
);

    logic [N-1:0][N-1:0] older;

    // older[i][j]: slot i is older than slot j (diagonal set so a slot never blocks itself)
    always_comb begin
        older = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                older[i][j] = (i == j) ? 1'b1 : is_older(age[i], age[j]);
    end

    // a requester wins when it is older than every other requester
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++)
            grant[i] = req[i] & (&(older[i] | ~req));
    end

    assign gnt_vld = |req;

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: holds dispatched uops until operands are ready, issues oldest first.
module int_issue_queue
    import int_issue_queue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    int_issue_queue_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]                 slot_vld;
    logic [DEPTH-1:0]                 slot_rs1v;
    logic [DEPTH-1:0]                 slot_rs2v;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] slot_data;
    logic [DEPTH-1:0][PREG_WIDTH-1:0] slot_rs1;
    logic [DEPTH-1:0][PREG_WIDTH-1:0] slot_rs2;
    rob_idx_t [DEPTH-1:0]             slot_rob;
    logic [CNT_W-1:0]                 count;

    logic [DEPTH-1:0]                 slot_wk1, slot_wk2, cand, grant, kill;
    logic [ENQ_WIDTH-1:0]             dis_wk1, dis_wk2;
    logic [ENQ_WIDTH-1:0][DEPTH-1:0]  alloc;
    logic [CNT_W-1:0]                 enq_n;
    logic                             enq_ok, sel_vld, load;
    logic [DATA_WIDTH-1:0]            sel_data;
    logic [PREG_WIDTH-1:0]            sel_rs1, sel_rs2;
    rob_idx_t                         sel_rob;

    function automatic logic wake_hit(
        input logic [PREG_WIDTH-1:0]               preg,
        input logic [WB_WIDTH-1:0]                 en,
        input logic [WB_WIDTH-1:0][PREG_WIDTH-1:0] pregs
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_WIDTH; k++)
            hit = hit | (en[k] & (pregs[k] == preg));
        return hit;
    endfunction

    assign bus.full = (CNT_W'(DEPTH) - count) < CNT_W'(ENQ_WIDTH);
    assign enq_ok   = ~bus.full & ~bus.redirect;

    // wakeup matches for stored slots and for incoming uops
    always_comb begin
        slot_wk1 = '0;
        slot_wk2 = '0;
        dis_wk1  = '0;
        dis_wk2  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            slot_wk1[s] = wake_hit(slot_rs1[s], bus.wakeup_en, bus.wakeup_preg);
            slot_wk2[s] = wake_hit(slot_rs2[s], bus.wakeup_en, bus.wakeup_preg);
        end
        for (int p = 0; p < ENQ_WIDTH; p++) begin
            dis_wk1[p] = wake_hit(bus.dis_rs1[p], bus.wakeup_en, bus.wakeup_preg);
            dis_wk2[p] = wake_hit(bus.dis_rs2[p], bus.wakeup_en, bus.wakeup_preg);
        end
    end

    // lowest free slot to the lowest active port; slots freed this edge still look busy
    always_comb begin
        logic [DEPTH-1:0] avail;
        logic             found;
        alloc = '0;
        enq_n = '0;
        avail = ~slot_vld;
        found = 1'b0;
        for (int p = 0; p < ENQ_WIDTH; p++) begin
            found = 1'b0;
            if (enq_ok && bus.dis_en[p]) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (!found && avail[s]) begin
                        alloc[p][s] = 1'b1;
                        avail[s]    = 1'b0;
                        found       = 1'b1;
                    end
                end
                enq_n = enq_n + CNT_W'(found);
            end
        end
    end

    assign cand = slot_vld & slot_rs1v & slot_rs2v;

    age_select #(.N(DEPTH)) u_sel (
        .req     (cand),
        .age     (slot_rob),
        .grant   (grant),
        .gnt_vld (sel_vld)
    );

    assign load = ~bus.redirect & sel_vld & (~bus.issue_valid | bus.issue_ready);

    // one-hot mux of the granted slot
    always_comb begin
        sel_data = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        sel_rob  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (grant[s]) begin
                sel_data = slot_data[s];
                sel_rs1  = slot_rs1[s];
                sel_rs2  = slot_rs2[s];
                sel_rob  = slot_rob[s];
            end
        end
    end

    // slots strictly younger than the redirect point are squashed
    always_comb begin
        kill = '0;
        for (int s = 0; s < DEPTH; s++)
            kill[s] = slot_vld[s] & is_older(bus.redirect_idx, slot_rob[s]);
    end

    // slot state: free on issue/flush, set ready bits on wakeup, write on enqueue
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld  <= '0;
            slot_rs1v <= '0;
            slot_rs2v <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (bus.redirect) begin
                    if (kill[s]) slot_vld[s] <= 1'b0;
                end else if (load && grant[s]) begin
                    slot_vld[s] <= 1'b0;
                end
                if (slot_vld[s] && slot_wk1[s]) slot_rs1v[s] <= 1'b1;
                if (slot_vld[s] && slot_wk2[s]) slot_rs2v[s] <= 1'b1;
                for (int p = 0; p < ENQ_WIDTH; p++) begin
                    if (alloc[p][s]) begin
                        slot_vld[s]  <= 1'b1;
                        slot_data[s] <= bus.dis_data[p];
                        slot_rs1[s]  <= bus.dis_rs1[p];
                        slot_rs2[s]  <= bus.dis_rs2[p];
                        slot_rob[s]  <= bus.dis_robIdx[p];
                        slot_rs1v[s] <= bus.dis_rs1v[p] | dis_wk1[p];
                        slot_rs2v[s] <= bus.dis_rs2v[p] | dis_wk2[p];
                    end
                end
            end
        end
    end

    // occupancy: exact recount on redirect, incremental otherwise
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (bus.redirect)
            count <= CNT_W'($countones(slot_vld & ~kill));
        else
            count <= count + enq_n - CNT_W'(load);
    end

    // issue output register; a redirect drops a younger op or one the FU takes this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.issue_valid  <= 1'b0;
            bus.issue_data   <= '0;
            bus.issue_rs1    <= '0;
            bus.issue_rs2    <= '0;
            bus.issue_robIdx <= '0;
        end else if (bus.redirect) begin
            if (bus.issue_valid && (bus.issue_ready || is_older(bus.redirect_idx, bus.issue_robIdx)))
                bus.issue_valid <= 1'b0;
        end else if (load) begin
            bus.issue_valid  <= 1'b1;
            bus.issue_data   <= sel_data;
            bus.issue_rs1    <= sel_rs1;
            bus.issue_rs2    <= sel_rs2;
            bus.issue_robIdx <= sel_rob;
        end else if (bus.issue_ready) begin
            bus.issue_valid <= 1'b0;
        end
    end

endmodule
